digit_scan_driver: RTL and testbench

- Four-digit time-multiplexed display driver feeding the shared 4-bit-to-seven-segment decoder.
- Holds a 16-bit display value (four nibbles) and scans the digits round-robin.
- Presents one nibble at a time on w,x,y,z to the decoder.
- Drives active-low digit enables, with tear-free value updates, leading-zero blanking, anti-ghost dead time and blink.

---
 rtl/digit_scan_driver_if.sv | 26 ++
 rtl/digit_scan_driver.sv | 138 +++++++++++++
 tb/tb_digit_scan_driver.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/digit_scan_driver_if.sv
// Host-side control and display-side outputs of the four-digit scan driver.
// master drives value/control, slave is the driver itself.
interface digit_scan_driver_if;
    logic        load;
    logic [15:0] value_in;
    logic        blank_lz;
    logic        blink_en;
    logic        w;
    logic        x;
    logic        y;
    logic        z;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_tick;
    logic        pending;

    modport master (
        output load, value_in, blank_lz, blink_en,
        input  w, x, y, z, an, digit_idx, frame_tick, pending
    );

    modport slave (
        input  load, value_in, blank_lz, blink_en,
        output w, x, y, z, an, digit_idx, frame_tick, pending
    );
endinterface

// File: rtl/digit_scan_driver.sv
// Four-digit multiplexed display scanner: shadow/active value swap at frame
// boundaries, leading-zero blanking, anti-ghost dead time and whole-display blink.
module digit_scan_driver #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DEAD_CYC    = 16,
    parameter int unsigned BLINK_DIV   = 12500000
) (
    input  logic               clk,
    input  logic               resetn,
    digit_scan_driver_if.slave bus
);

    localparam int unsigned SLOT_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BLINK_W = $clog2(BLINK_DIV + 1);

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0]  DEAD_END   = SLOT_W'(DEAD_CYC);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    // registered state
    logic [SLOT_W-1:0]  slot_cnt;
    logic [1:0]         digit_idx_q;
    logic [15:0]        active;
    logic [15:0]        shadow;
    logic               pending_q;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic [3:0]         an_q;
    logic [3:0]         nib_q;
    logic               frame_tick_q;

    // next-state values
    logic [SLOT_W-1:0]  nxt_slot;
    logic [1:0]         nxt_idx;
    logic [15:0]        nxt_active;
    logic [15:0]        nxt_shadow;
    logic               nxt_pending;
    logic [BLINK_W-1:0] nxt_blink_cnt;
    logic               nxt_blink_phase;
    logic [3:0]         nxt_an;
    logic [3:0]         nxt_nib;
    logic               nxt_frame_tick;
    logic               slot_wrap;
    logic               frame_end;
    logic [3:0]         lz;
    logic [3:0]         blank;

    always_comb begin
        nxt_slot        = slot_cnt + SLOT_W'(1);
        nxt_idx         = digit_idx_q;
        nxt_active      = active;
        nxt_shadow      = shadow;
        nxt_pending     = pending_q;
        nxt_blink_cnt   = blink_cnt;
        nxt_blink_phase = blink_phase;
        nxt_an          = 4'hF;
        nxt_nib         = 4'h0;
        nxt_frame_tick  = 1'b0;
        lz              = 4'b0000;
        blank           = 4'b0000;

        // slot counter and round-robin digit index
        slot_wrap = (slot_cnt == SLOT_LAST);
        frame_end = slot_wrap && (digit_idx_q == 2'd3);
        if (slot_wrap) begin
            nxt_slot = '0;
            nxt_idx  = digit_idx_q + 2'd1;
        end

        // active takes the old shadow at the boundary; a coincident load refills the shadow
        if (bus.load) begin
            nxt_shadow = bus.value_in;
        end
        nxt_pending = bus.load | (pending_q & ~frame_end);
        if (frame_end && pending_q) begin
            nxt_active = shadow;
        end

        if (!bus.blink_en) begin
            nxt_blink_cnt   = '0;
            nxt_blink_phase = 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            nxt_blink_cnt   = '0;
            nxt_blink_phase = ~blink_phase;
        end else begin
            nxt_blink_cnt   = blink_cnt + BLINK_W'(1);
        end

        // digit k blanks only if it and every digit to its left are zero
        lz[3] = (nxt_active[15:12] == 4'h0);
        lz[2] = lz[3] && (nxt_active[11:8] == 4'h0);
        lz[1] = lz[2] && (nxt_active[7:4] == 4'h0);
        lz[0] = 1'b0;
        blank = lz & {4{bus.blank_lz}};

        nxt_nib = nxt_active[{nxt_idx, 2'b00} +: 4];
        if ((nxt_slot >= DEAD_END) && !nxt_blink_phase && !blank[nxt_idx]) begin
            nxt_an[nxt_idx] = 1'b0;
        end
        nxt_frame_tick = (nxt_slot == '0) && (nxt_idx == 2'd0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_cnt     <= '0;
            digit_idx_q  <= 2'd0;
            active       <= 16'h0000;
            shadow       <= 16'h0000;
            pending_q    <= 1'b0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            an_q         <= 4'hF;
            nib_q        <= 4'h0;
            frame_tick_q <= 1'b0;
        end else begin
            slot_cnt     <= nxt_slot;
            digit_idx_q  <= nxt_idx;
            active       <= nxt_active;
            shadow       <= nxt_shadow;
            pending_q    <= nxt_pending;
            blink_cnt    <= nxt_blink_cnt;
            blink_phase  <= nxt_blink_phase;
            an_q         <= nxt_an;
            nib_q        <= nxt_nib;
            frame_tick_q <= nxt_frame_tick;
        end
    end

    assign bus.w          = nib_q[3];
    assign bus.x          = nib_q[2];
    assign bus.y          = nib_q[1];
    assign bus.z          = nib_q[0];
    assign bus.an         = an_q;
    assign bus.digit_idx  = digit_idx_q;
    assign bus.frame_tick = frame_tick_q;
    assign bus.pending    = pending_q;

endmodule

// File: tb/tb_digit_scan_driver.sv
// Directed bench for digit_scan_driver with REFRESH_DIV=4, DEAD_CYC=1, BLINK_DIV=8.
module tb_digit_scan_driver;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;
    int   cyc;

    digit_scan_driver_if bus ();

    digit_scan_driver #(
        .REFRESH_DIV (4),
        .DEAD_CYC    (1),
        .BLINK_DIV   (8)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // cycle c after reset release: slot = c%4, digit = (c/4)%4
    function automatic logic [3:0] exp_an(input int c, input logic [15:0] val,
                                          input logic blz, input logic off);
        int         slot;
        int         idx;
        logic       blanked;
        logic [3:0] m;
        slot    = c % 4;
        idx     = (c / 4) % 4;
        blanked = blz && (idx >= 1) && ((val >> (4 * idx)) == 16'h0000);
        if (off || (slot < 1) || blanked) return 4'hF;
        m = 4'b0001 << idx;
        return ~m;
    endfunction

    function automatic logic [3:0] exp_nib(input int c, input logic [15:0] val);
        logic [15:0] sh;
        sh = val >> (4 * ((c / 4) % 4));
        return sh[3:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // check one whole frame, starting at a frame start
    task automatic check_frame(input logic [15:0] val, input logic blz);
        for (int i = 0; i < 16; i++) begin
            check("digit_idx", 32'((cyc / 4) % 4), 32'(bus.digit_idx));
            check("nibble", 32'({bus.w, bus.x, bus.y, bus.z}), 32'(exp_nib(cyc, val)));
            check("an", 32'(bus.an), 32'(exp_an(cyc, val, blz, 1'b0)));
            check("frame_tick", 32'(bus.frame_tick), 32'((cyc % 16 == 0) && (cyc != 0)));
            tick();
        end
    endtask

    // advance to frame position pos, confirming the old value stays on display
    task automatic hold_until(input int pos, input logic [15:0] old_val);
        while (cyc % 16 != pos) begin
            check("hold_nibble", 32'({bus.w, bus.x, bus.y, bus.z}), 32'(exp_nib(cyc, old_val)));
            tick();
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        resetn       = 1'b0;
        bus.load     = 1'b0;
        bus.value_in = 16'h0000;
        bus.blank_lz = 1'b0;
        bus.blink_en = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_an", 32'(bus.an), 32'h0000000F);
        check("rst_nibble", 32'({bus.w, bus.x, bus.y, bus.z}), 32'h0);
        check("rst_digit_idx", 32'(bus.digit_idx), 32'h0);
        check("rst_frame_tick", 32'(bus.frame_tick), 32'h0);
        check("rst_pending", 32'(bus.pending), 32'h0);
        resetn = 1'b1;

        // basic load and scan
        bus.load = 1'b1; bus.value_in = 16'h1A3F;
        tick();
        bus.load = 1'b0;
        check("pending_set", 32'(bus.pending), 32'h1);
        hold_until(15, 16'h0000);
        check("pending_before_boundary", 32'(bus.pending), 32'h1);
        tick();
        check("pending_cleared", 32'(bus.pending), 32'h0);
        check_frame(16'h1A3F, 1'b0);

        // tear-free update: two loads inside one frame, last wins
        hold_until(5, 16'h1A3F);
        bus.load = 1'b1; bus.value_in = 16'h1234;
        tick();
        bus.load = 1'b0;
        hold_until(9, 16'h1A3F);
        bus.load = 1'b1; bus.value_in = 16'h5678;
        tick();
        bus.load = 1'b0;
        check("pending_two_loads", 32'(bus.pending), 32'h1);
        hold_until(0, 16'h1A3F);
        check("pending_after_swap", 32'(bus.pending), 32'h0);
        check_frame(16'h5678, 1'b0);

        // load coincident with the frame boundary edge
        bus.load = 1'b1; bus.value_in = 16'h0001;
        tick();
        bus.load = 1'b0;
        hold_until(15, 16'h5678);
        check("pending_pre_coincident", 32'(bus.pending), 32'h1);
        bus.load = 1'b1; bus.value_in = 16'hBEEF;
        tick();
        bus.load = 1'b0;
        check("pending_coincident", 32'(bus.pending), 32'h1);
        check_frame(16'h0001, 1'b0);
        check("pending_after_beef", 32'(bus.pending), 32'h0);
        check_frame(16'hBEEF, 1'b0);

        // leading-zero blanking
        bus.blank_lz = 1'b1;
        bus.load = 1'b1; bus.value_in = 16'h0050;
        tick();
        bus.load = 1'b0;
        hold_until(0, 16'hBEEF);
        check_frame(16'h0050, 1'b1);
        bus.load = 1'b1; bus.value_in = 16'h0000;
        tick();
        bus.load = 1'b0;
        hold_until(0, 16'h0050);
        check_frame(16'h0000, 1'b1);
        bus.blank_lz = 1'b0;

        // blink: 8 cycles on, 8 off, then drop blink_en mid-off-phase
        bus.load = 1'b1; bus.value_in = 16'h8888;
        tick();
        bus.load = 1'b0;
        hold_until(0, 16'h0000);
        check_frame(16'h8888, 1'b0);
        bus.blink_en = 1'b1;
        for (int b = 1; b <= 41; b++) begin
            tick();
            check("blink_an", 32'(bus.an), 32'(exp_an(cyc, 16'h8888, 1'b0, ((b / 8) % 2) == 1)));
        end
        bus.blink_en = 1'b0;
        tick();
        check("blink_release_an", 32'(bus.an), 32'(exp_an(cyc, 16'h8888, 1'b0, 1'b0)));
        check("blink_release_lit", 32'(bus.an), 32'hB);

        // asynchronous reset mid-slot 2 with a pending value
        hold_until(9, 16'h8888);
        bus.load = 1'b1; bus.value_in = 16'h4321;
        tick();
        bus.load = 1'b0;
        check("pending_before_reset", 32'(bus.pending), 32'h1);
        check("idx_before_reset", 32'(bus.digit_idx), 32'h2);
        resetn = 1'b0;
        #1;
        check("async_rst_an", 32'(bus.an), 32'hF);
        check("async_rst_idx", 32'(bus.digit_idx), 32'h0);
        check("async_rst_pending", 32'(bus.pending), 32'h0);
        check("async_rst_nibble", 32'({bus.w, bus.x, bus.y, bus.z}), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("held_rst_an", 32'(bus.an), 32'hF);
        resetn = 1'b1;
        cyc = 0;
        check_frame(16'h0000, 1'b0);
        check_frame(16'h0000, 1'b0);
        check("pending_after_reset", 32'(bus.pending), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
